// File: rtl/mul_ace_core.sv
// Sequential unsigned shift-and-add multiply-accumulate engine.
// Optional feature: define MUL_ACE_SAT_EN to saturate the accumulator instead of wrapping.
module mul_ace_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || ACC_WIDTH < 2 * WIDTH) begin : g_bad_params
      $error("mul_ace_core: requires WIDTH >= 2 and ACC_WIDTH >= 2*WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             clr_q;
  logic [SW-1:0]    sum_c;

  // Accumulate at one extra bit so the carry out is the overflow indication.
  assign sum_c = {1'b0, result} + SW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      cnt       <= '0;
      clr_q     <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= PW'(a);
            mplier   <= b;
            clr_q    <= clr;
            prod     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ACC;
          end
        end
        ACC: begin
          if (clr_q) begin
            result   <= ACC_WIDTH'(prod);
            overflow <= 1'b0;
          end else begin
            if (sum_c[ACC_WIDTH]) begin
              overflow <= 1'b1;
            end
`ifdef MUL_ACE_SAT_EN
            result <= sum_c[ACC_WIDTH] ? '1 : sum_c[ACC_WIDTH-1:0];
`else
            result <= sum_c[ACC_WIDTH-1:0];
`endif
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ace_core.sv
// Directed self-checking bench; a 24-bit and a 16-bit accumulator instance run in lock-step.
module tb_mul_ace_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        clr;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] result;
  logic        overflow;
  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] result16;
  logic        overflow16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_ace_core #(.WIDTH(8), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  mul_ace_core #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .clr(clr), .out_valid(out_valid16), .out_ready(out_ready),
    .result(result16), .overflow(overflow16)
  );

  // Issue one operand pair and wait (bounded) for out_valid; lat = edges after the accept edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    clr = cv;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the output handshake and return to IDLE.
  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    in_valid = 1'b0; a = '0; b = '0; clr = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (result !== 24'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%0d in_ready=%b out_valid=%b overflow=%b, required 0 1 0 0",
               result, in_ready, out_valid, overflow);
    end
    run_op(8'd13, 8'd11, 1'b1, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL latency: got %0d edges, required 9", lat);
    end
    checks++;
    if (result !== 24'd143 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_op: result=%0d overflow=%b, required 143 0", result, overflow);
    end
    finish_op();
  endtask

  task automatic test_accumulate();
    int lat;
    run_op(8'd3, 8'd4, 1'b1, lat);
    checks++;
    if (result !== 24'd12) begin
      errors++;
      $display("FAIL acc_first: result=%0d, required 12", result);
    end
    finish_op();
    run_op(8'd5, 8'd6, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result !== 24'd42 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL acc_stall_%0d: result=%0d out_valid=%b, required 42 1", i, result, out_valid);
      end
      @(negedge clk);
    end
    finish_op();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL acc_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    run_op(8'd255, 8'd255, 1'b0, lat);
    checks++;
    if (result !== 24'd65067) begin
      errors++;
      $display("FAIL acc_third: result=%0d, required 65067", result);
    end
    finish_op();
  endtask

  task automatic test_overflow();
    int lat;
    logic [15:0] exp1;
    logic [15:0] exp2;
`ifdef MUL_ACE_SAT_EN
    exp1 = 16'd65535;
    exp2 = 16'd65535;
`else
    exp1 = 16'd64514;
    exp2 = 16'd64515;
`endif
    run_op(8'd255, 8'd255, 1'b1, lat);
    checks++;
    if (result16 !== 16'd65025 || overflow16 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_load: result=%0d overflow=%b, required 65025 0", result16, overflow16);
    end
    finish_op();
    run_op(8'd255, 8'd255, 1'b0, lat);
    checks++;
    if (result16 !== exp1 || overflow16 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_carry: result=%0d overflow=%b, required %0d 1", result16, overflow16, exp1);
    end
    checks++;
    if (result !== 24'd130050 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wide: result=%0d overflow=%b, required 130050 0", result, overflow);
    end
    finish_op();
    run_op(8'd1, 8'd1, 1'b0, lat);
    checks++;
    if (result16 !== exp2 || overflow16 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: result=%0d overflow=%b, required %0d 1", result16, overflow16, exp2);
    end
    finish_op();
    run_op(8'd2, 8'd2, 1'b1, lat);
    checks++;
    if (result16 !== 16'd4 || overflow16 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: result=%0d overflow=%b, required 4 0", result16, overflow16);
    end
    finish_op();
  endtask

  task automatic test_busy_reject();
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd7; b = 8'd9; clr = 1'b1;
    @(negedge clk);
    a = 8'd200; b = 8'd200; clr = 1'b0;
    while (!out_valid && guard < 50) begin
      in_valid = ~in_valid;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready_mul: in_ready=%b, required 0", in_ready);
      end
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL busy_ready_done: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (result !== 24'd63) begin
      errors++;
      $display("FAIL busy_result: result=%0d, required 63", result);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd100; b = 8'd100; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 24'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: result=%0d in_ready=%b out_valid=%b overflow=%b, required 0 1 0 0",
               result, in_ready, out_valid, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd2, 8'd3, 1'b1, lat);
    checks++;
    if (result !== 24'd6 || lat !== 9) begin
      errors++;
      $display("FAIL post_reset_op: result=%0d latency=%0d, required 6 9", result, lat);
    end
    finish_op();
  endtask

  task automatic test_corners();
    int lat;
    run_op(8'd0, 8'd255, 1'b1, lat);
    checks++;
    if (result !== 24'd0) begin
      errors++;
      $display("FAIL corner_zero: result=%0d, required 0", result);
    end
    finish_op();
    run_op(8'd255, 8'd1, 1'b1, lat);
    checks++;
    if (result !== 24'd255) begin
      errors++;
      $display("FAIL corner_one: result=%0d, required 255", result);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int last = -1;
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'd1; b = 8'd1; clr = 1'b0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && in_ready) begin
        errors++;
        $display("FAIL b2b_exclusive: out_valid=%b in_ready=%b at cycle %0d, required not both 1",
                 out_valid, in_ready, cyc);
      end
      if (out_valid) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 11) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles, required 11", cyc - last);
          end
        end
        last = cyc;
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 3 || result !== 24'd258) begin
      errors++;
      $display("FAIL b2b_result: ops=%0d result=%0d, required 3 258", n, result);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_overflow();
    test_busy_reject();
    test_reset_mid_op();
    test_corners();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
